uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a two-flop input synchroniser,
// false-start rejection, parity/framing error flags and a small receive FIFO.
//
// Parameters:
//   CLKS_PER_BIT  rx_clk cycles per bit (>= 4)
//   DATA_BITS     data bits per frame (5..9), LSB first
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//   FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//
// Ports:
//   rx_clk     in   receiver clock
//   rx_rst     in   synchronous active-high reset
//   rx_in      in   serial line, idle high, asynchronous to rx_clk
//   rx_out     out  data word at the FIFO head (0 when empty)
//   rx_valid   out  FIFO non-empty; rx_out/rx_perr/rx_ferr are valid
//   rx_ready   in   consumer accepts the head entry
//   rx_perr    out  head entry had a parity error
//   rx_ferr    out  head entry had a framing error
//   overrun    out  one-cycle pulse: completed frame dropped, FIFO full
//   dbg_state  out  receive FSM state (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP)
//
// Handshake: an entry is transferred on every rising edge where
// rx_valid && rx_ready. rx_valid never depends on rx_ready, and the head
// entry holds stable while rx_valid = 1 and rx_ready = 0.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 overrun,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_HALF    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST    = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   N_FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- synchroniser and start-edge detect ----------------
    logic       r_sync1, r_sync2, r_prev;
    logic [2:0] r_real;
    logic       w_rxs, w_fall;

    // r_real marks which stages hold real line samples rather than reset
    // values, so a line already low at reset release never looks like an edge.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_real  <= 3'b000;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_real  <= {r_real[1:0], 1'b1};
        end
    end

    assign w_rxs  = r_sync2;
    assign w_fall = r_real[2] & r_prev & ~r_sync2;

    // ---------------- receive FSM ----------------
    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_bit;
    logic                  r_stop;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_perr, r_ferr;
    logic                  w_tick, w_mid, w_cnt_clr, w_push, w_par_x;

    assign w_tick  = (r_cnt == C_LAST);
    assign w_mid   = (r_cnt == C_HALF);
    assign w_par_x = (^r_shift) ^ w_rxs;

    always_ff @(posedge rx_clk) begin
        if (rx_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_mid) w_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && r_bit == I_LAST)
                          w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_next = S_STOP;
            S_STOP:   if (w_tick && r_stop == STOP_LAST) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clr = 1'b0;
        w_push    = 1'b0;
        case (r_state)
            S_IDLE:   w_cnt_clr = 1'b1;
            S_START:  w_cnt_clr = w_mid;
            S_DATA,
            S_PARITY: w_cnt_clr = w_tick;
            S_STOP: begin
                w_cnt_clr = w_tick;
                w_push    = w_tick && (r_stop == STOP_LAST);
            end
            default:  w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_START: if (w_mid) begin
                    r_bit  <= '0;
                    r_stop <= 1'b0;
                    r_perr <= 1'b0;
                    r_ferr <= 1'b0;
                end
                S_DATA: if (w_tick) begin
                    r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                    r_bit   <= r_bit + 1'b1;
                end
                // Odd parity expects the XOR of data and parity to be 1.
                S_PARITY: if (w_tick) r_perr <= (PARITY == 1) ? ~w_par_x : w_par_x;
                S_STOP: if (w_tick) begin
                    if (!w_rxs) r_ferr <= 1'b1;
                    r_stop <= r_stop + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          w_full, w_empty, w_pop, w_wr;
    logic [EW-1:0] w_head;

    assign w_full  = (r_count == N_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & rx_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // that is being drained still succeeds.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge rx_clk) begin
        if (w_wr) r_mem[r_wr] <= {r_shift, r_perr, r_ferr | ~w_rxs};
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overrun <= w_push & w_full & ~w_pop;
        end
    end

    assign w_head    = r_mem[r_rd];
    assign rx_valid  = ~w_empty;
    assign rx_out    = rx_valid ? w_head[EW-1:2] : '0;
    assign rx_perr   = rx_valid ? w_head[1] : 1'b0;
    assign rx_ferr   = rx_valid ? w_head[0] : 1'b0;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int CPB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] out_a, out_b;
    logic       val_a, val_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;
    logic [2:0] st_a, st_b;

    int checks = 0;
    int failures = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;

    // Entries are {data[7:0], perr, ferr}.
    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];

    // 8N1 receiver
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .rx_clk(clk), .rx_rst(rst), .rx_in(rx_a), .rx_out(out_a),
        .rx_valid(val_a), .rx_ready(rdy_a), .rx_perr(perr_a),
        .rx_ferr(ferr_a), .overrun(ovr_a), .dbg_state(st_a));

    // 8E2 receiver
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .rx_clk(clk), .rx_rst(rst), .rx_in(rx_b), .rx_out(out_b),
        .rx_valid(val_b), .rx_ready(rdy_b), .rx_perr(perr_b),
        .rx_ferr(ferr_b), .overrun(ovr_b), .dbg_state(st_b));

    always @(negedge clk) begin
        if (ovr_a === 1'b1) ovr_cnt_a++;
        if (ovr_b === 1'b1) ovr_cnt_b++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [9:0] model_a(input logic [7:0] d, input logic stop_v);
        return {d, 1'b0, (stop_v == 1'b0)};
    endfunction

    // Even parity: the frame is wrong when data plus parity holds an odd number of ones.
    function automatic logic [9:0] model_b(input logic [7:0] d, input logic par,
                                           input logic [1:0] stop);
        logic pe, fe;
        pe = ($countones({d, par}) % 2) != 0;
        fe = (stop != 2'b11);
        return {d, pe, fe};
    endfunction

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_v);
        rx_a = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            idle(CPB);
        end
        rx_a = stop_v;
        idle(CPB);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic [1:0] stop);
        rx_b = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_b = d[i];
            idle(CPB);
        end
        rx_b = par;
        idle(CPB);
        rx_b = stop[0];
        idle(CPB);
        rx_b = stop[1];
        idle(CPB);
        rx_b = 1'b1;
    endtask

    // Waits (bounded) for an entry, captures it and pops it with one handshake.
    task automatic recv_a(output bit ok, output logic [9:0] e);
        ok = 0;
        e  = '0;
        for (int i = 0; i < CPB * 24; i++) begin
            if (val_a === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            e = {out_a, perr_a, ferr_a};
            rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0;
        end
    endtask

    task automatic recv_b(output bit ok, output logic [9:0] e);
        ok = 0;
        e  = '0;
        for (int i = 0; i < CPB * 24; i++) begin
            if (val_b === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            e = {out_b, perr_b, ferr_b};
            rdy_b = 1'b1;
            @(negedge clk);
            rdy_b = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        rx_a = 1'b0;   // line held low across reset release
        rx_b = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        idle(4);
        rst = 1'b0;
        idle(1);
        checks++;
        if ({val_a, out_a, perr_a, ferr_a, ovr_a} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs_a: got %h required 000", {val_a, out_a, perr_a, ferr_a, ovr_a});
        end
        checks++;
        if ({val_b, out_b, perr_b, ferr_b, ovr_b} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs_b: got %h required 000", {val_b, out_b, perr_b, ferr_b, ovr_b});
        end
        checks++;
        if (st_b !== 3'd0) begin
            failures++;
            $display("FAIL reset_state_b: got %0d required 0", st_b);
        end
        idle(3 * CPB);
        checks++;
        if (st_a !== 3'd0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL low_at_release: state %0d valid %b required 0 0", st_a, val_a);
        end
        rx_a = 1'b1;
        idle(CPB);
    endtask

    task automatic test_nominal;
        logic [9:0] e, got;
        bit ok;
        e = model_a(8'hE3, 1'b1);
        send_a(8'hE3, 1'b1);
        ok = 0;
        for (int i = 0; i < CPB * 4; i++) begin
            if (val_a === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        got = {out_a, perr_a, ferr_a};
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL nominal_entry: got %h valid %b required %h", got, ok, e);
        end
        idle(5);
        checks++;
        if (val_a !== 1'b1 || {out_a, perr_a, ferr_a} !== e) begin
            failures++;
            $display("FAIL output_hold: got %h valid %b required %h", {out_a, perr_a, ferr_a}, val_a, e);
        end
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if (val_a !== 1'b0) begin
            failures++;
            $display("FAIL valid_fall: got %b required 0", val_a);
        end
    endtask

    task automatic test_even_parity;
        logic [9:0] e, got;
        bit ok;
        logic [7:0] d[6];
        logic       p[6];
        logic [1:0] s[6];
        send_b(8'hA5, 1'b0, 2'b11);
        recv_b(ok, got);
        checks++;
        if (!ok || got !== model_b(8'hA5, 1'b0, 2'b11)) begin
            failures++;
            $display("FAIL parity_good: got %h ok %b required %h", got, ok, model_b(8'hA5, 1'b0, 2'b11));
        end
        send_b(8'hA5, 1'b1, 2'b11);
        recv_b(ok, got);
        checks++;
        if (!ok || got !== model_b(8'hA5, 1'b1, 2'b11)) begin
            failures++;
            $display("FAIL parity_bad: got %h ok %b required %h", got, ok, model_b(8'hA5, 1'b1, 2'b11));
        end
        for (int i = 0; i < 6; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            p[i] = 1'($urandom_range(0, 1));
            s[i] = 2'($urandom_range(0, 3));
            exp_q_b.push_back(model_b(d[i], p[i], s[i]));
        end
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_b(d[i], p[i], s[i]);
                    idle(2 * CPB);
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    recv_b(ok, got);
                    e = exp_q_b.pop_front();
                    checks++;
                    if (!ok || got !== e) begin
                        failures++;
                        $display("FAIL random_8e2[%0d]: got %h ok %b required %h", j, got, ok, e);
                    end
                end
            end
        join
    endtask

    task automatic test_framing;
        logic [9:0] got;
        bit ok;
        send_a(8'h3C, 1'b0);
        idle(CPB);
        recv_a(ok, got);
        checks++;
        if (!ok || got !== model_a(8'h3C, 1'b0)) begin
            failures++;
            $display("FAIL framing_err: got %h ok %b required %h", got, ok, model_a(8'h3C, 1'b0));
        end
        send_a(8'h55, 1'b1);
        recv_a(ok, got);
        checks++;
        if (!ok || got !== model_a(8'h55, 1'b1)) begin
            failures++;
            $display("FAIL after_framing: got %h ok %b required %h", got, ok, model_a(8'h55, 1'b1));
        end
    endtask

    task automatic test_false_start;
        logic [9:0] got;
        bit ok;
        rx_a = 1'b0;
        idle(10);      // well under half a bit
        rx_a = 1'b1;
        idle(3 * CPB);
        checks++;
        if (st_a !== 3'd0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL false_start: state %0d valid %b required 0 0", st_a, val_a);
        end
        send_a(8'h81, 1'b1);
        recv_a(ok, got);
        checks++;
        if (!ok || got !== model_a(8'h81, 1'b1)) begin
            failures++;
            $display("FAIL after_false_start: got %h ok %b required %h", got, ok, model_a(8'h81, 1'b1));
        end
    endtask

    task automatic test_overrun_wrap;
        logic [9:0] e, got;
        bit ok;
        int ovr0, exp_ovr;
        for (int pass = 0; pass < 2; pass++) begin
            ovr0 = ovr_cnt_a;
            exp_ovr = 0;
            exp_q_a.delete();
            for (int v = 1; v <= 5 - pass; v++) begin
                logic [7:0] dv;
                dv = 8'(v + 5 * pass);
                if (exp_q_a.size() < 4) exp_q_a.push_back(model_a(dv, 1'b1));
                else exp_ovr++;
                send_a(dv, 1'b1);
            end
            idle(4);
            checks++;
            if (ovr_cnt_a - ovr0 !== exp_ovr) begin
                failures++;
                $display("FAIL overrun_count[%0d]: got %0d required %0d", pass, ovr_cnt_a - ovr0, exp_ovr);
            end
            for (int j = 0; j < 4; j++) begin
                recv_a(ok, got);
                e = exp_q_a.pop_front();
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL drain[%0d][%0d]: got %h ok %b required %h", pass, j, got, ok, e);
                end
            end
            checks++;
            if (val_a !== 1'b0) begin
                failures++;
                $display("FAIL drained_empty[%0d]: valid %b required 0", pass, val_a);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] e, got;
        bit ok;
        logic [7:0] d[8];
        for (int i = 0; i < 8; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            exp_q_a.push_back(model_a(d[i], 1'b1));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send_a(d[i], 1'b1);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    recv_a(ok, got);
                    e = exp_q_a.pop_front();
                    checks++;
                    if (!ok || got !== e) begin
                        failures++;
                        $display("FAIL back_to_back[%0d]: got %h ok %b required %h", j, got, ok, e);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] got;
        logic [12:0] snap;
        bit ok;
        fork
            send_a(8'hFF, 1'b1);
            begin
                idle(5 * CPB + CPB / 2);  // middle of data bit 4
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
                idle(1);
                snap = {val_a, out_a, perr_a, ferr_a, ovr_a};
            end
        join
        checks++;
        if (snap !== 13'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h required 0", snap);
        end
        idle(2 * CPB);
        checks++;
        if (val_a !== 1'b0 || st_a !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_discard: valid %b state %0d required 0 0", val_a, st_a);
        end
        send_a(8'h5A, 1'b1);
        recv_a(ok, got);
        checks++;
        if (!ok || got !== model_a(8'h5A, 1'b1)) begin
            failures++;
            $display("FAIL after_reset_mid: got %h ok %b required %h", got, ok, model_a(8'h5A, 1'b1));
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        @(negedge clk);
        test_reset;
        test_nominal;
        test_even_parity;
        test_framing;
        test_false_start;
        test_overrun_wrap;
        test_back_to_back;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
